// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: FSM encoding, field widths and
// the MEM/WB pipeline record layout.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  // {ALU[31:0], MEM[31:0], rd[4:0], reg_write, mem_to_reg}, 71 bits
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_to_reg;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with bubble insertion and the write-back data mux.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  mem_wb_t           d,
  output logic [DATA_W-1:0] dato_wb,
  output logic [REG_W-1:0]  rd_wb,
  output logic              reg_write_wb
);

  mem_wb_t q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= bubble ? '0 : d;
    end
  end

  assign dato_wb      = q.mem_to_reg ? q.mem : q.alu;
  assign rd_wb        = q.rd;
  assign reg_write_wb = q.reg_write;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues req/ack data-memory transactions,
// stalls upstream while waiting, and feeds the MEM/WB register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic              reloj,
  input  logic              resetMEM,
  input  logic              enableMEM,
  input  logic [DATA_W-1:0] DIR_MEM,
  input  logic [DATA_W-1:0] DI_MEM,
  input  logic [REG_W-1:0]  rd_rt,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              stall,
  output logic [DATA_W-1:0] DATO_WB,
  output logic [REG_W-1:0]  rd_wb,
  output logic              reg_write_wb,
  output logic              align_err,
  output logic              bus_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] lat_alu_q, lat_alu_d;
  logic [REG_W-1:0]  lat_rd_q, lat_rd_d;
  logic              lat_rw_q, lat_rw_d;
  logic              lat_m2r_q, lat_m2r_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              align_err_q, align_err_d;

  logic    is_mem, aligned, timeout;
  logic    wb_load, wb_bubble;
  mem_wb_t wb_d;

  assign is_mem  = mem_read | mem_write;
  assign aligned = (DIR_MEM[1:0] == 2'b00);
  assign timeout = (cnt_q == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_alu_d   = lat_alu_q;
    lat_rd_d    = lat_rd_q;
    lat_rw_d    = lat_rw_q;
    lat_m2r_d   = lat_m2r_q;
    rdata_d     = rdata_q;
    bus_err_d   = bus_err_q;
    align_err_d = 1'b0;
    stall       = 1'b0;
    wb_load     = 1'b0;
    wb_bubble   = 1'b0;
    wb_d        = '0;

    unique case (state_q)
      StIdle: begin
        if (is_mem && aligned) begin
          stall     = 1'b1;
          req_d     = 1'b1;
          we_d      = mem_write;
          addr_d    = {DIR_MEM[DATA_W-1:2], 2'b00};
          wdata_d   = DI_MEM;
          lat_alu_d = DIR_MEM;
          lat_rd_d  = rd_rt;
          lat_rw_d  = reg_write;
          lat_m2r_d = mem_to_reg;
          cnt_d     = '0;
          wb_load   = enableMEM;
          wb_bubble = 1'b1;
          state_d   = StAccess;
        end else if (is_mem) begin
          // Misaligned access is dropped, never reaches the bus.
          align_err_d = 1'b1;
          wb_load     = enableMEM;
          wb_bubble   = 1'b1;
        end else begin
          wb_load         = enableMEM;
          wb_d.alu        = DIR_MEM;
          wb_d.rd         = rd_rt;
          wb_d.reg_write  = reg_write;
          wb_d.mem_to_reg = mem_to_reg;
        end
      end

      StAccess: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dm_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = dm_rdata;
          if (enableMEM) begin
            wb_load         = 1'b1;
            wb_d.alu        = lat_alu_q;
            wb_d.mem        = dm_rdata;
            wb_d.rd         = lat_rd_q;
            wb_d.reg_write  = lat_rw_q;
            wb_d.mem_to_reg = lat_m2r_q;
            state_d         = StIdle;
          end else begin
            state_d = StDone;
          end
        end else if (timeout) begin
          // Abort: instruction is dropped, upstream released this cycle.
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
          wb_load   = enableMEM;
          wb_bubble = 1'b1;
          state_d   = StIdle;
        end else begin
          stall     = 1'b1;
          wb_load   = enableMEM;
          wb_bubble = 1'b1;
        end
      end

      StDone: begin
        if (enableMEM) begin
          wb_load         = 1'b1;
          wb_d.alu        = lat_alu_q;
          wb_d.mem        = rdata_q;
          wb_d.rd         = lat_rd_q;
          wb_d.reg_write  = lat_rw_q;
          wb_d.mem_to_reg = lat_m2r_q;
          state_d         = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (resetMEM) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_alu_q   <= '0;
      lat_rd_q    <= '0;
      lat_rw_q    <= 1'b0;
      lat_m2r_q   <= 1'b0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_alu_q   <= lat_alu_d;
      lat_rd_q    <= lat_rd_d;
      lat_rw_q    <= lat_rw_d;
      lat_m2r_q   <= lat_m2r_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign dm_req    = req_q;
  assign dm_we     = we_q;
  assign dm_addr   = addr_q;
  assign dm_wdata  = wdata_q;
  assign bus_err   = bus_err_q;
  assign align_err = align_err_q;

  mem_wb_reg u_mem_wb_reg (
    .clk          (reloj),
    .rst          (resetMEM),
    .load         (wb_load),
    .bubble       (wb_bubble),
    .d            (wb_d),
    .dato_wb      (DATO_WB),
    .rd_wb        (rd_wb),
    .reg_write_wb (reg_write_wb)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single-cycle ops,
// hand-written sequences for load/store/timeout/reset/DONE behaviour.
module tb_mem_access_stage;

  logic        reloj = 1'b0;
  logic        resetMEM, enableMEM;
  logic [31:0] DIR_MEM, DI_MEM, dm_addr, dm_wdata, dm_rdata, DATO_WB;
  logic [4:0]  rd_rt, rd_wb;
  logic        mem_read, mem_write, reg_write, mem_to_reg;
  logic        dm_req, dm_we, dm_ack, stall, reg_write_wb, align_err, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 reloj = ~reloj;

  mem_access_stage #(.MAX_WAIT(16), .CNT_W(5)) dut (
    .reloj        (reloj),
    .resetMEM     (resetMEM),
    .enableMEM    (enableMEM),
    .DIR_MEM      (DIR_MEM),
    .DI_MEM       (DI_MEM),
    .rd_rt        (rd_rt),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dm_ack       (dm_ack),
    .stall        (stall),
    .DATO_WB      (DATO_WB),
    .rd_wb        (rd_wb),
    .reg_write_wb (reg_write_wb),
    .align_err    (align_err),
    .bus_err      (bus_err)
  );

  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [31:0] dir;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        en;
    logic        chk_data;
    logic [31:0] e_dato;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_align;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic set_in(input logic rd_op, input logic wr_op, input logic [31:0] dir,
                        input logic [31:0] di, input logic [4:0] rd, input logic rw,
                        input logic m2r, input logic en);
    mem_read   = rd_op;
    mem_write  = wr_op;
    DIR_MEM    = dir;
    DI_MEM     = di;
    rd_rt      = rd;
    reg_write  = rw;
    mem_to_reg = m2r;
    enableMEM  = en;
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 5'd5,  1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'hABCD_0000, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 32'hABCD_0000, 5'd31, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0055, 5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 32'hABCD_0000, 5'd31, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0007, 5'd2,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0007, 5'd2,  1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0102, 5'd4,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          5'd0,  1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0203, 5'd6,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          5'd0,  1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_1234, 5'd1,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 5'd1,  1'b1, 1'b0};

    // Reset state
    resetMEM = 1'b1;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    resetMEM = 1'b0;
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    check("rst_dato_wb", DATO_WB, 32'd0);
    check("rst_rd_wb", 32'(rd_wb), 32'd0);
    check("rst_reg_write_wb", 32'(reg_write_wb), 32'd0);
    check("rst_align_err", 32'(align_err), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // Single-cycle ops: ALU pass-through, hold, misaligned drops
    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].rd_op, vecs[i].wr_op, vecs[i].dir, 32'h0, vecs[i].rd, vecs[i].rw,
             vecs[i].m2r, vecs[i].en);
      #1;
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      tick();
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_dato_wb", i), DATO_WB, vecs[i].e_dato);
        check($sformatf("vec%0d_rd_wb", i), 32'(rd_wb), 32'(vecs[i].e_rd));
      end
      check($sformatf("vec%0d_reg_write_wb", i), 32'(reg_write_wb), 32'(vecs[i].e_rw));
      check($sformatf("vec%0d_align_err", i), 32'(align_err), 32'(vecs[i].e_align));
      check($sformatf("vec%0d_dm_req", i), 32'(dm_req), 32'd0);
    end

    // Load with ack in the third ACCESS cycle: three stall cycles
    set_in(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1);
    #1;
    check("ld_stall_accept", 32'(stall), 32'd1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("ld_req_c%0d", c), 32'(dm_req), 32'd1);
      check($sformatf("ld_addr_c%0d", c), dm_addr, 32'h0000_0100);
      check($sformatf("ld_we_c%0d", c), 32'(dm_we), 32'd0);
      check($sformatf("ld_bubble_c%0d", c), 32'(reg_write_wb), 32'd0);
      if (c == 3) begin
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEAD_BEEF;
      end
      #1;
      check($sformatf("ld_stall_c%0d", c), 32'(stall), (c == 3) ? 32'd0 : 32'd1);
      tick();
    end
    dm_ack = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("ld_dato_wb", DATO_WB, 32'hDEAD_BEEF);
    check("ld_rd_wb", 32'(rd_wb), 32'd7);
    check("ld_reg_write_wb", 32'(reg_write_wb), 32'd1);
    check("ld_req_drop", 32'(dm_req), 32'd0);

    // Store acked in the first ACCESS cycle
    set_in(1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("st_stall_accept", 32'(stall), 32'd1);
    tick();
    check("st_req", 32'(dm_req), 32'd1);
    check("st_we", 32'(dm_we), 32'd1);
    check("st_addr", dm_addr, 32'h0000_0204);
    check("st_wdata", dm_wdata, 32'h1234_5678);
    dm_ack = 1'b1;
    #1;
    check("st_stall_ack", 32'(stall), 32'd0);
    tick();
    dm_ack = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("st_we_drop", 32'(dm_we), 32'd0);
    check("st_req_drop", 32'(dm_req), 32'd0);
    check("st_reg_write_wb", 32'(reg_write_wb), 32'd0);

    // No ack: abort after MAX_WAIT request cycles
    set_in(1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1);
    #1;
    check("to_stall_accept", 32'(stall), 32'd1);
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dm_req) break;
      n++;
      if (n == 16) begin
        check("to_stall_abort", 32'(stall), 32'd0);
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      end else if (stall !== 1'b1) begin
        check($sformatf("to_stall_wait%0d", n), 32'(stall), 32'd1);
      end
      tick();
    end
    check("to_req_cycles", 32'(n), 32'd16);
    check("to_req_drop", 32'(dm_req), 32'd0);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_reg_write_wb", 32'(reg_write_wb), 32'd0);
    dm_ack = 1'b1;
    set_in(1'b0, 1'b0, 32'h0000_0044, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    check("to_late_ack_stall", 32'(stall), 32'd0);
    tick();
    dm_ack = 1'b0;
    check("to_late_ack_req", 32'(dm_req), 32'd0);
    check("to_next_alu_dato", DATO_WB, 32'h0000_0044);
    check("to_next_alu_rd", 32'(rd_wb), 32'd9);
    check("to_next_alu_rw", 32'(reg_write_wb), 32'd1);
    tick();
    check("to_bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset during ACCESS, ack arriving the following cycle
    set_in(1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1);
    tick();
    check("rs_req_before", 32'(dm_req), 32'd1);
    resetMEM = 1'b1;
    tick();
    resetMEM = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    dm_ack   = 1'b1;
    dm_rdata = 32'h1111_1111;
    check("rs_req", 32'(dm_req), 32'd0);
    check("rs_addr", dm_addr, 32'd0);
    check("rs_bus_err", 32'(bus_err), 32'd0);
    check("rs_dato_wb", DATO_WB, 32'd0);
    check("rs_reg_write_wb", 32'(reg_write_wb), 32'd0);
    #1;
    check("rs_stall", 32'(stall), 32'd0);
    tick();
    dm_ack = 1'b0;
    check("rs_late_ack_dato", DATO_WB, 32'd0);
    check("rs_late_ack_rw", 32'(reg_write_wb), 32'd0);
    check("rs_late_ack_req", 32'(dm_req), 32'd0);

    // Ack while enableMEM=0: result parked in DONE until enabled
    set_in(1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1);
    #1;
    check("dn_stall_accept", 32'(stall), 32'd1);
    tick();
    dm_ack    = 1'b1;
    dm_rdata  = 32'hCAFE_F00D;
    enableMEM = 1'b0;
    #1;
    check("dn_stall_ack", 32'(stall), 32'd0);
    tick();
    dm_ack = 1'b0;
    set_in(1'b0, 1'b0, 32'h0000_0020, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("dn_hold_stall%0d", c), 32'(stall), 32'd0);
      check($sformatf("dn_hold_req%0d", c), 32'(dm_req), 32'd0);
      check($sformatf("dn_hold_rw%0d", c), 32'(reg_write_wb), 32'd0);
      tick();
    end
    enableMEM = 1'b1;
    tick();
    check("dn_dato_wb", DATO_WB, 32'hCAFE_F00D);
    check("dn_rd_wb", 32'(rd_wb), 32'd12);
    check("dn_reg_write_wb", 32'(reg_write_wb), 32'd1);
    tick();
    check("dn_back_idle_dato", DATO_WB, 32'h0000_0020);
    check("dn_back_idle_rw", 32'(reg_write_wb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
